mem_req_arbiter: RTL and testbench

Shares the single memory-side request port of `axi_top` (the mem-to-AXI bridge) between `NumPorts` memory-style requesters. Arbitrates requests round-robin, forwards the winner's address, write enable, write data and byte enables downstream, and tracks granted transactions in an in-order ID FIFO. Returned `rvalid`/`err` are routed back to the originating requester. Sits directly in front of `axi_top`'s `mem_req_i` … `mem_be_i` inputs.

---
 rtl/mem_req_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one memory-side request port between NumPorts
// requesters. A round-robin (or fixed-priority) arbiter selects the winner
// and forwards its payload downstream. An in-order ID FIFO records granted
// ports so that responses are steered back to the requester that issued them.
//
// Build option: define MEM_REQ_ARBITER_FIXED_PRIO_EN for fixed priority
// (lowest index wins, no round-robin pointer). Default is round-robin.
module mem_req_arbiter #(
  parameter int NumPorts    = 2,
  parameter int AddrWidth   = 5,
  parameter int DataWidth   = 32,
  parameter int MaxRequests = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumPorts-1:0]             req_i,
  output logic [NumPorts-1:0]             gnt_o,
  input  logic [NumPorts*AddrWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0]             we_i,
  input  logic [NumPorts*DataWidth-1:0]   wdata_i,
  input  logic [NumPorts*DataWidth/8-1:0] be_i,
  output logic [NumPorts-1:0]             rvalid_o,
  output logic [DataWidth-1:0]            rdata_o,
  output logic [NumPorts-1:0]             err_o,
  output logic                            mem_req_o,
  output logic [AddrWidth-1:0]            mem_addr_o,
  output logic                            mem_we_o,
  output logic [DataWidth-1:0]            mem_wdata_o,
  output logic [DataWidth/8-1:0]          mem_be_o,
  input  logic                            mem_gnt_i,
  input  logic                            mem_rvalid_i,
  input  logic [DataWidth-1:0]            mem_rdata_i,
  input  logic                            mem_err_i,
  output logic                            unexp_rsp_o
);

  localparam int BeWidth = DataWidth / 8;
  localparam int IdxW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int PtrW    = (MaxRequests > 1) ? $clog2(MaxRequests) : 1;
  localparam int CntW    = $clog2(MaxRequests + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam idx_t LastPort  = idx_t'(NumPorts - 1);
  localparam ptr_t LastSlot  = ptr_t'(MaxRequests - 1);
  localparam cnt_t FullCount = cnt_t'(MaxRequests);

  // Arbitration state
  logic lock_q;
  idx_t lock_idx_q;
`ifndef MEM_REQ_ARBITER_FIXED_PRIO_EN
  idx_t rr_q;
`endif

  // ID FIFO state
  idx_t fifo_mem [MaxRequests];
  ptr_t wr_ptr_q;
  ptr_t rd_ptr_q;
  cnt_t count_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic [NumPorts-1:0] eligible;
  logic                win_valid;
  idx_t                win_idx;
  logic                push;
  logic                pop;
  idx_t                fifo_head;

  assign fifo_full  = (count_q == FullCount);
  assign fifo_empty = (count_q == '0);

  // Full FIFO blocks new arbitration; reset also forces the request side quiet.
  assign eligible = (fifo_full || rst_i) ? '0 : req_i;

  // Winner selection: held lock, else first eligible port from the search base.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    idx_t cand;
`ifndef MEM_REQ_ARBITER_FIXED_PRIO_EN
    logic [IdxW:0] sum;
    sum = '0;
`endif
    cand      = '0;
    win_valid = 1'b0;
    win_idx   = '0;
    if (lock_q) begin
      win_valid = 1'b1;
      win_idx   = lock_idx_q;
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
`ifdef MEM_REQ_ARBITER_FIXED_PRIO_EN
        cand = idx_t'(i);
`else
        sum = {1'b0, rr_q} + (IdxW + 1)'(i);
        if (sum > {1'b0, LastPort}) begin
          sum = sum - (IdxW + 1)'(NumPorts);
        end
        cand = sum[IdxW-1:0];
`endif
        if (!win_valid && eligible[cand]) begin
          win_valid = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  assign mem_req_o = win_valid;
  assign push      = win_valid & mem_gnt_i;

  // Downstream payload mux; all zeros when nobody is selected.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (win_valid) begin
      mem_addr_o  = addr_i[int'(win_idx)*AddrWidth +: AddrWidth];
      mem_we_o    = we_i[win_idx];
      mem_wdata_o = wdata_i[int'(win_idx)*DataWidth +: DataWidth];
      mem_be_o    = be_i[int'(win_idx)*BeWidth +: BeWidth];
    end
  end

  // Grant returned to the winning requester on the downstream handshake.
  always_comb begin
    gnt_o = '0;
    if (push) begin
      gnt_o[win_idx] = 1'b1;
    end
  end

  assign fifo_head   = fifo_mem[rd_ptr_q];
  assign pop         = mem_rvalid_i & ~fifo_empty;
  assign unexp_rsp_o = mem_rvalid_i & fifo_empty & ~rst_i;
  assign rdata_o     = mem_rdata_i;

  // Response steering to the port at the head of the ID FIFO.
  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    if (pop) begin
      rvalid_o[fifo_head] = 1'b1;
      err_o[fifo_head]    = mem_err_i;
    end
  end

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LastSlot) ? '0 : p + 1'b1;
  endfunction

  // Lock holds the winner while the downstream port stalls the request.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= win_valid & ~mem_gnt_i;
      lock_idx_q <= win_idx;
    end
  end

`ifndef MEM_REQ_ARBITER_FIXED_PRIO_EN
  // Round-robin pointer moves past the port that just completed a handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (push) begin
      rr_q <= (win_idx == LastPort) ? '0 : win_idx + 1'b1;
    end
  end
`endif

  // ID FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ID FIFO storage.
  // NOTE: storage is deliberately not reset; entries are only read while the
  // count says they are valid, and the count itself is reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= win_idx;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter (NumPorts=2, AddrWidth=5, DataWidth=32,
// MaxRequests=3). Directed stimulus pushes expected grants and responses into
// queues; a monitor pops and compares whenever the DUT grants or responds.
module tb_mem_req_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_i;
  logic [1:0]  gnt_o;
  logic [9:0]  addr_i;
  logic [1:0]  we_i;
  logic [63:0] wdata_i;
  logic [7:0]  be_i;
  logic [1:0]  rvalid_o;
  logic [31:0] rdata_o;
  logic [1:0]  err_o;
  logic        mem_req_o;
  logic [4:0]  mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        unexp_rsp_o;

  mem_req_arbiter #(
    .NumPorts(2), .AddrWidth(5), .DataWidth(32), .MaxRequests(3)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .be_i(be_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_err_i(mem_err_i), .unexp_rsp_o(unexp_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    logic [1:0]  gnt;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } gnt_exp_t;

  typedef struct {
    int          cyc;
    logic [1:0]  rvalid;
    logic [1:0]  err;
    logic [31:0] rdata;
  } rsp_exp_t;

  gnt_exp_t gq[$];
  rsp_exp_t rq[$];
  int cyc = 0;
  int cmp_count = 0;
  int err_count = 0;

  // Expected winner sequences that depend on the arbitration mode.
`ifdef MEM_REQ_ARBITER_FIXED_PRIO_EN
  int rr_p[4]   = '{0, 0, 0, 0};
  int full_p[4] = '{0, 0, 0, 0};
`else
  int rr_p[4]   = '{0, 1, 0, 1};
  int full_p[4] = '{1, 0, 1, 0};
`endif

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_addr(input logic [4:0] a0, input logic [4:0] a1);
    addr_i = {a1, a0};
  endtask

  // Port payload constants: port0 writes A0A0_0000 with be F, port1 reads.
  task automatic exp_grant(input int port, input logic [4:0] addr);
    gnt_exp_t e;
    e.cyc   = cyc;
    e.gnt   = (port == 0) ? 2'b01 : 2'b10;
    e.addr  = addr;
    e.we    = (port == 0) ? 1'b1 : 1'b0;
    e.wdata = (port == 0) ? 32'hA0A0_0000 : 32'hB1B1_0001;
    e.be    = (port == 0) ? 4'hF : 4'h3;
    gq.push_back(e);
  endtask

  task automatic exp_rsp(input int port, input logic err, input logic [31:0] rdata);
    rsp_exp_t e;
    e.cyc    = cyc;
    e.rvalid = (port == 0) ? 2'b01 : 2'b10;
    e.err    = err ? e.rvalid : 2'b00;
    e.rdata  = rdata;
    rq.push_back(e);
  endtask

  // Monitor: compare every grant and every response against the queues.
  always @(negedge clk_i) begin
    if (gnt_o != 2'b00) begin
      if (gq.size() == 0) begin
        check("grant_unexpected", 64'(gnt_o), 64'd0);
      end else begin
        gnt_exp_t g;
        g = gq.pop_front();
        check("grant_cycle", 64'(cyc), 64'(g.cyc));
        check("grant_onehot", 64'(gnt_o), 64'(g.gnt));
        check("grant_addr", 64'(mem_addr_o), 64'(g.addr));
        check("grant_we", 64'(mem_we_o), 64'(g.we));
        check("grant_wdata", 64'(mem_wdata_o), 64'(g.wdata));
        check("grant_be", 64'(mem_be_o), 64'(g.be));
      end
    end
    if (rvalid_o != 2'b00) begin
      if (rq.size() == 0) begin
        check("rsp_unexpected", 64'(rvalid_o), 64'd0);
      end else begin
        rsp_exp_t r;
        r = rq.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(r.cyc));
        check("rsp_rvalid", 64'(rvalid_o), 64'(r.rvalid));
        check("rsp_err", 64'(err_o), 64'(r.err));
        check("rsp_rdata", 64'(rdata_o), 64'(r.rdata));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, 64'(mem_req_o), 64'd0);
    check({tag, "_gnt"}, 64'(gnt_o), 64'd0);
    check({tag, "_rvalid"}, 64'(rvalid_o), 64'd0);
    check({tag, "_err"}, 64'(err_o), 64'd0);
    check({tag, "_unexp"}, 64'(unexp_rsp_o), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr_o), 64'd0);
    check({tag, "_we"}, 64'(mem_we_o), 64'd0);
    check({tag, "_wdata"}, 64'(mem_wdata_o), 64'd0);
    check({tag, "_be"}, 64'(mem_be_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i        = 1'b1;
    req_i        = 2'b00;
    we_i         = 2'b01;
    wdata_i      = {32'hB1B1_0001, 32'hA0A0_0000};
    be_i         = {4'h3, 4'hF};
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_err_i    = 1'b0;
    set_addr(5'h00, 5'h00);

    // Reset and idle after release
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("reset");

    // Round-robin with both ports requesting, response one cycle after grant
    set_addr(5'h01, 5'h02);
    for (int c = 0; c < 5; c++) begin
      step();
      req_i        = (c < 4) ? 2'b11 : 2'b00;
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = (c > 0);
      mem_rdata_i  = 32'h100 + 32'(c);
      if (c < 4) exp_grant(rr_p[c], (rr_p[c] == 0) ? 5'h01 : 5'h02);
      if (c > 0) exp_rsp(rr_p[c-1], 1'b0, 32'h100 + 32'(c));
    end
    step();
    req_i = 2'b00; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;

    // Lock: port1 stalled for 3 cycles, port0 joins in the third
    set_addr(5'h11, 5'h04);
    for (int c = 0; c < 3; c++) begin
      step();
      req_i     = (c == 2) ? 2'b11 : 2'b10;
      mem_gnt_i = 1'b0;
      @(negedge clk_i);
      check("lock_mem_req", 64'(mem_req_o), 64'd1);
      check("lock_addr", 64'(mem_addr_o), 64'h04);
      check("lock_gnt", 64'(gnt_o), 64'd0);
    end
    step();
    req_i = 2'b11; mem_gnt_i = 1'b1;
    exp_grant(1, 5'h04);
    step();
    exp_grant(0, 5'h11);
    step();
    req_i = 2'b00; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h200;
    exp_rsp(1, 1'b0, 32'h200);
    step();
    mem_rdata_i = 32'h201;
    exp_rsp(0, 1'b0, 32'h201);
    step();
    mem_rvalid_i = 1'b0;

    // FIFO full: three grants, block, pop, re-request next cycle
    set_addr(5'h0A, 5'h0B);
    for (int c = 0; c < 3; c++) begin
      step();
      req_i = 2'b11; mem_gnt_i = 1'b1;
      exp_grant(full_p[c], (full_p[c] == 0) ? 5'h0A : 5'h0B);
    end
    step();
    @(negedge clk_i);
    check("full_block_req", 64'(mem_req_o), 64'd0);
    check("full_block_gnt", 64'(gnt_o), 64'd0);
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h300; mem_err_i = 1'b0;
    exp_rsp(full_p[0], 1'b0, 32'h300);
    @(negedge clk_i);
    check("full_pop_same_cycle_req", 64'(mem_req_o), 64'd0);
    step();
    mem_rvalid_i = 1'b0;
    exp_grant(full_p[3], (full_p[3] == 0) ? 5'h0A : 5'h0B);
    @(negedge clk_i);
    check("full_reassert_req", 64'(mem_req_o), 64'd1);
    step();
    req_i = 2'b00; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h301; mem_err_i = 1'b1;
    exp_rsp(full_p[1], 1'b1, 32'h301);
    step();
    mem_rdata_i = 32'h302; mem_err_i = 1'b0;
    exp_rsp(full_p[2], 1'b0, 32'h302);
    step();
    mem_rdata_i = 32'h303;
    exp_rsp(full_p[3], 1'b0, 32'h303);
    step();
    mem_rvalid_i = 1'b0;

    // Ordered routing: grants port0, port1, port0; error on the second
    set_addr(5'h03, 5'h13);
    step();
    req_i = 2'b01; mem_gnt_i = 1'b1;
    exp_grant(0, 5'h03);
    step();
    req_i = 2'b10;
    exp_grant(1, 5'h13);
    step();
    req_i = 2'b01;
    exp_grant(0, 5'h03);
    step();
    req_i = 2'b00; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA; mem_err_i = 1'b0;
    exp_rsp(0, 1'b0, 32'hA);
    step();
    mem_rdata_i = 32'hB; mem_err_i = 1'b1;
    exp_rsp(1, 1'b1, 32'hB);
    step();
    mem_rdata_i = 32'hC; mem_err_i = 1'b0;
    exp_rsp(0, 1'b0, 32'hC);
    step();
    mem_rvalid_i = 1'b0;

    // Unexpected response with the FIFO empty
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; mem_err_i = 1'b1;
    @(negedge clk_i);
    check("unexp_pulse", 64'(unexp_rsp_o), 64'd1);
    check("unexp_rvalid", 64'(rvalid_o), 64'd0);
    check("unexp_err", 64'(err_o), 64'd0);
    check("unexp_rdata", 64'(rdata_o), 64'hDEAD_BEEF);
    step();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    @(negedge clk_i);
    check("unexp_clear", 64'(unexp_rsp_o), 64'd0);

    // Asynchronous reset mid-cycle with an outstanding ID and a stalled request
    step();
    set_addr(5'h07, 5'h08);
    req_i = 2'b01; mem_gnt_i = 1'b1;
    exp_grant(0, 5'h07);
    step();
    req_i = 2'b11; mem_gnt_i = 1'b0;
    @(negedge clk_i);
    check("pre_reset_mem_req", 64'(mem_req_o), 64'd1);
    #2;
    rst_i = 1'b1;
    mem_gnt_i = 1'b1;
    #1;
    check_all_zero("async_reset");
    step();
    req_i = 2'b00; mem_gnt_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_reset_mem_req", 64'(mem_req_o), 64'd0);
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h400;
    @(negedge clk_i);
    check("post_reset_unexp", 64'(unexp_rsp_o), 64'd1);
    check("post_reset_rvalid", 64'(rvalid_o), 64'd0);
    step();
    mem_rvalid_i = 1'b0;

    step();
    check("grant_queue_drained", 64'(gq.size()), 64'd0);
    check("rsp_queue_drained", 64'(rq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
